// File: rtl/clock_pkg.sv
// clock_pkg: definitions shared by the clock time-setting controller.
//   - field index constants (bit positions in the per-field mode/up/down buses)
//   - number of counter fields
//   - set-mode state enumeration plus small decode helpers
package clock_pkg;

  localparam int NUM_FIELDS = 6;

  localparam logic [2:0] FIELD_SEC   = 3'd0;
  localparam logic [2:0] FIELD_MIN   = 3'd1;
  localparam logic [2:0] FIELD_HOUR  = 3'd2;
  localparam logic [2:0] FIELD_DAY   = 3'd3;
  localparam logic [2:0] FIELD_MONTH = 3'd4;
  localparam logic [2:0] FIELD_YEAR  = 3'd5;
  localparam logic [2:0] FIELD_NONE  = 3'd7;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_SEC   = 3'd3,
    SET_DAY   = 3'd4,
    SET_MONTH = 3'd5,
    SET_YEAR  = 3'd6
  } set_state_t;

  // Mode-button successor: RUN -> HOUR -> MIN -> SEC -> DAY -> MONTH -> YEAR -> RUN
  function automatic set_state_t next_state(input set_state_t st);
    set_state_t n;
    case (st)
      RUN:       n = SET_HOUR;
      SET_HOUR:  n = SET_MIN;
      SET_MIN:   n = SET_SEC;
      SET_SEC:   n = SET_DAY;
      SET_DAY:   n = SET_MONTH;
      SET_MONTH: n = SET_YEAR;
      SET_YEAR:  n = RUN;
      default:   n = RUN;
    endcase
    return n;
  endfunction

  // Field edited in a given state; FIELD_NONE when running
  function automatic logic [2:0] field_of(input set_state_t st);
    logic [2:0] f;
    case (st)
      SET_HOUR:  f = FIELD_HOUR;
      SET_MIN:   f = FIELD_MIN;
      SET_SEC:   f = FIELD_SEC;
      SET_DAY:   f = FIELD_DAY;
      SET_MONTH: f = FIELD_MONTH;
      SET_YEAR:  f = FIELD_YEAR;
      default:   f = FIELD_NONE;
    endcase
    return f;
  endfunction

  // One-hot bus bit for a field index; all zero for FIELD_NONE
  function automatic logic [NUM_FIELDS-1:0] field_mask(input logic [2:0] f);
    logic [NUM_FIELDS-1:0] m;
    case (f)
      3'd0:    m = 6'b000001;
      3'd1:    m = 6'b000010;
      3'd2:    m = 6'b000100;
      3'd3:    m = 6'b001000;
      3'd4:    m = 6'b010000;
      3'd5:    m = 6'b100000;
      default: m = 6'b000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_cond.sv
// btn_cond: conditioning for one push-button.
//   2-flop synchronizer, rising-edge detector and synchronized level.
//   With CLOCK_SET_AUTO_REPEAT_EN defined it also owns the auto-repeat counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   btn          raw (debounced, asynchronous) level, high = pressed
//   rpt_en       repeat allowed (controller is in a set state)
//   rpt_clr      clear the repeat counter (state change)
//   rise_o       one-cycle press strobe (rising edge of synchronized level)
//   level_o      synchronized level
//   rpt_o        one-cycle auto-repeat strobe (always 0 without the macro)
module btn_cond #(
  parameter int RPT_DELAY_CYC = 25_000_000,
  parameter int RPT_RATE_CYC  = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic rpt_en,
  input  logic rpt_clr,
  output logic rise_o,
  output logic level_o,
  output logic rpt_o
);

  // [0],[1] synchronizer stages, [2] previous synchronized level
  logic [2:0] sync_r;

  // Synchronizer and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], btn};
    end
  end

  assign level_o = sync_r[1];
  assign rise_o  = sync_r[1] & ~sync_r[2];

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY_CYC > RPT_RATE_CYC) ? RPT_DELAY_CYC : RPT_RATE_CYC;
  localparam int RW      = $clog2(RPT_MAX + 1);

  // cnt_r == 0 means dormant; it starts at 1 in the cycle after the press
  // strobe, so reaching N marks N cycles since the previous pulse.
  logic [RW-1:0] cnt_r;
  logic          rate_phase_r;
  logic [RW-1:0] target_s;

  assign target_s = rate_phase_r ? RW'(RPT_RATE_CYC) : RW'(RPT_DELAY_CYC);
  assign rpt_o    = rpt_en & level_o & (cnt_r != '0) & (cnt_r == target_s);

  // Repeat counter: armed by a press, reloaded at each repeat pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= '0;
      rate_phase_r <= 1'b0;
    end else if (rpt_clr || !rpt_en || !level_o) begin
      cnt_r        <= '0;
      rate_phase_r <= 1'b0;
    end else if (rise_o) begin
      cnt_r        <= RW'(1);
      rate_phase_r <= 1'b0;
    end else if (rpt_o) begin
      cnt_r        <= RW'(1);
      rate_phase_r <= 1'b1;
    end else if (cnt_r != '0) begin
      cnt_r        <= cnt_r + RW'(1);
      rate_phase_r <= rate_phase_r;
    end else begin
      cnt_r        <= cnt_r;
      rate_phase_r <= rate_phase_r;
    end
  end
`else
  logic unused_s;
  assign unused_s = rpt_en ^ rpt_clr ^ ((RPT_DELAY_CYC + RPT_RATE_CYC) > 0);
  assign rpt_o    = 1'b0;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for the clock counter chain.
//   Turns mode/up/down buttons into per-field mode/up/down controls and
//   exports field-select and blink state to the display driver.
//   Optional feature macro: CLOCK_SET_AUTO_REPEAT_EN (held up/down auto-repeat).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   btn_mode/up/down      debounced asynchronous buttons, high = pressed
//   tick_1hz              one-cycle strobe per second
//   mode_o[5:0]           per-field mode, 1 = count, 0 = set
//   up_o[5:0], down_o[5:0] per-field one-cycle inc/dec pulses
//   sel_o[2:0]            edited field, 7 = none
//   blink_o               blank phase for the selected field
//   editing_o             high in any set state
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S     = 10,
  parameter int RPT_DELAY_CYC = 25_000_000,
  parameter int RPT_RATE_CYC  = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_mode,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  tick_1hz,
  output logic [NUM_FIELDS-1:0] mode_o,
  output logic [NUM_FIELDS-1:0] up_o,
  output logic [NUM_FIELDS-1:0] down_o,
  output logic [2:0]            sel_o,
  output logic                  blink_o,
  output logic                  editing_o
);

  localparam int            IW   = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [IW-1:0] TO_V = IW'(TIMEOUT_S);

  set_state_t    state_r;
  set_state_t    nxt_state_s;
  logic [IW-1:0] idle_r;

  logic mode_rise_s, up_rise_s, down_rise_s;
  logic mode_lvl_unused_s, up_lvl_s, down_lvl_s;
  logic mode_rpt_unused_s, up_rpt_s, down_rpt_s;
  logic in_set_s, timeout_s, state_chg_s, up_acc_s, down_acc_s;

  btn_cond #(.RPT_DELAY_CYC(RPT_DELAY_CYC), .RPT_RATE_CYC(RPT_RATE_CYC)) u_mode (
    .clk(clk), .rst_n(rst_n), .btn(btn_mode), .rpt_en(1'b0), .rpt_clr(1'b1),
    .rise_o(mode_rise_s), .level_o(mode_lvl_unused_s), .rpt_o(mode_rpt_unused_s)
  );
  btn_cond #(.RPT_DELAY_CYC(RPT_DELAY_CYC), .RPT_RATE_CYC(RPT_RATE_CYC)) u_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .rpt_en(in_set_s), .rpt_clr(state_chg_s),
    .rise_o(up_rise_s), .level_o(up_lvl_s), .rpt_o(up_rpt_s)
  );
  btn_cond #(.RPT_DELAY_CYC(RPT_DELAY_CYC), .RPT_RATE_CYC(RPT_RATE_CYC)) u_down (
    .clk(clk), .rst_n(rst_n), .btn(btn_down), .rpt_en(in_set_s), .rpt_clr(state_chg_s),
    .rise_o(down_rise_s), .level_o(down_lvl_s), .rpt_o(down_rpt_s)
  );

  // Event arbitration: timeout beats mode, mode beats up/down, and an up/down
  // event is dropped while the opposite button is held (covers simultaneous edges).
  always_comb begin
    in_set_s    = (state_r != RUN);
    timeout_s   = in_set_s && (TIMEOUT_S != 0) && (idle_r == TO_V);
    state_chg_s = timeout_s | mode_rise_s;
    up_acc_s    = in_set_s & ~state_chg_s & (up_rise_s | up_rpt_s) & ~down_lvl_s;
    down_acc_s  = in_set_s & ~state_chg_s & (down_rise_s | down_rpt_s) & ~up_lvl_s;
    if (timeout_s) begin
      nxt_state_s = RUN;
    end else if (mode_rise_s) begin
      nxt_state_s = next_state(state_r);
    end else begin
      nxt_state_s = state_r;
    end
  end

  // FSM, idle timer, blink phase and registered output decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RUN;
      idle_r    <= '0;
      blink_o   <= 1'b0;
      mode_o    <= 6'h3F;
      up_o      <= 6'h00;
      down_o    <= 6'h00;
      sel_o     <= FIELD_NONE;
      editing_o <= 1'b0;
    end else begin
      state_r   <= nxt_state_s;
      mode_o    <= (nxt_state_s == RUN) ? 6'h3F : 6'h00;
      sel_o     <= field_of(nxt_state_s);
      editing_o <= (nxt_state_s != RUN);
      up_o      <= up_acc_s   ? field_mask(field_of(state_r)) : 6'h00;
      down_o    <= down_acc_s ? field_mask(field_of(state_r)) : 6'h00;

      if (state_chg_s || up_acc_s || down_acc_s) begin
        idle_r <= '0;
      end else if (in_set_s && tick_1hz && (TIMEOUT_S != 0)) begin
        idle_r <= idle_r + IW'(1);
      end else begin
        idle_r <= idle_r;
      end

      // Blink restarts in the visible phase on every state entry
      if (nxt_state_s == RUN || state_chg_s) begin
        blink_o <= 1'b0;
      end else if (tick_1hz) begin
        blink_o <= ~blink_o;
      end else begin
        blink_o <= blink_o;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl.
module tb_clock_set_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, tick_1hz = 1'b0;
  logic [5:0] mode_o, up_o, down_o;
  logic [2:0] sel_o;
  logic       blink_o, editing_o;
  int         checks = 0;
  int         errors = 0;

  clock_set_ctrl #(.TIMEOUT_S(3), .RPT_DELAY_CYC(8), .RPT_RATE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .tick_1hz(tick_1hz), .mode_o(mode_o), .up_o(up_o),
    .down_o(down_o), .sel_o(sel_o), .blink_o(blink_o), .editing_o(editing_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, {26'd0, mode_o}, 32'h3F);
    chk({tag, "_sel"}, {29'd0, sel_o}, 32'd7);
    chk({tag, "_up"}, {26'd0, up_o}, 32'd0);
    chk({tag, "_down"}, {26'd0, down_o}, 32'd0);
    chk({tag, "_blink"}, {31'd0, blink_o}, 32'd0);
    chk({tag, "_edit"}, {31'd0, editing_o}, 32'd0);
  endtask

  // One-cycle mode press; new state must appear exactly 3 cycles later
  task automatic press_mode(input logic [2:0] prev_sel, input logic [2:0] exp_sel);
    btn_mode = 1'b1;
    cyc(1);
    btn_mode = 1'b0;
    cyc(1);
    chk("mode_lat2_sel", {29'd0, sel_o}, {29'd0, prev_sel});
    cyc(1);
    chk("mode_sel", {29'd0, sel_o}, {29'd0, exp_sel});
    chk("mode_mode", {26'd0, mode_o}, (exp_sel == 3'd7) ? 32'h3F : 32'h00);
    chk("mode_edit", {31'd0, editing_o}, (exp_sel == 3'd7) ? 32'd0 : 32'd1);
    cyc(2);
  endtask

  // One-cycle up (is_down=0) or down (is_down=1) press; pulse 1 cycle wide at +3
  task automatic pulse_btn(input logic is_down, input logic [5:0] exp_mask);
    if (is_down) btn_down = 1'b1; else btn_up = 1'b1;
    cyc(1);
    btn_down = 1'b0;
    btn_up   = 1'b0;
    cyc(1);
    chk("pulse_pre", {20'd0, up_o, down_o}, 32'd0);
    cyc(1);
    chk("pulse_up", {26'd0, up_o}, is_down ? 32'd0 : {26'd0, exp_mask});
    chk("pulse_down", {26'd0, down_o}, is_down ? {26'd0, exp_mask} : 32'd0);
    cyc(1);
    chk("pulse_post", {20'd0, up_o, down_o}, 32'd0);
    cyc(1);
  endtask

  task automatic tick(input logic exp_blink);
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    chk("blink", {31'd0, blink_o}, {31'd0, exp_blink});
  endtask

  initial begin
    logic [5:0] exp_up;
    logic [2:0] seq [7];
    seq = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd4, 3'd5, 3'd7};

    // Reset
    cyc(2);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cyc(2);

    // Up press in RUN is ignored
    btn_up = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      cyc(1);
      if (j == 1) btn_up = 1'b0;
      chk("run_up", {26'd0, up_o}, 32'd0);
      chk("run_mode", {26'd0, mode_o}, 32'h3F);
      chk("run_sel", {29'd0, sel_o}, 32'd7);
    end

    // Full mode cycle
    for (int i = 0; i < 7; i++) press_mode((i == 0) ? 3'd7 : seq[i-1], seq[i]);

    // Field routing in SET_MONTH
    for (int i = 0; i < 5; i++) press_mode((i == 0) ? 3'd7 : seq[i-1], seq[i]);
    pulse_btn(1'b0, 6'b010000);
    pulse_btn(1'b0, 6'b010000);
    pulse_btn(1'b1, 6'b010000);

    // Up and down rising together: nothing
    btn_up = 1'b1;
    btn_down = 1'b1;
    cyc(1);
    btn_up = 1'b0;
    btn_down = 1'b0;
    for (int j = 2; j <= 5; j++) begin
      cyc(1);
      chk("both_none", {20'd0, up_o, down_o}, 32'd0);
    end

    // MONTH -> YEAR -> RUN -> HOUR
    press_mode(3'd4, 3'd5);
    press_mode(3'd5, 3'd7);
    press_mode(3'd7, 3'd2);

    // Up held, then down pressed: down dropped
    btn_up = 1'b1;
    cyc(3);
    chk("held_up_first", {26'd0, up_o}, 32'b000100);
    cyc(2);
    btn_down = 1'b1;
    cyc(1);
    btn_down = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cyc(1);
      chk("held_down_none", {26'd0, down_o}, 32'd0);
    end
    btn_up = 1'b0;
    cyc(4);

    // Mode and up together in SET_HOUR: mode wins
    btn_mode = 1'b1;
    btn_up = 1'b1;
    cyc(1);
    btn_mode = 1'b0;
    btn_up = 1'b0;
    for (int j = 2; j <= 5; j++) begin
      cyc(1);
      chk("mode_up_up", {26'd0, up_o}, 32'd0);
      chk("mode_up_sel", {29'd0, sel_o}, (j == 2) ? 32'd2 : 32'd1);
    end

    // Timeout and blink in SET_DAY
    press_mode(3'd1, 3'd0);
    press_mode(3'd0, 3'd3);
    chk("blink_entry", {31'd0, blink_o}, 32'd0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    chk("to_sel_last", {29'd0, sel_o}, 32'd3);
    cyc(1);
    chk("to_sel_run", {29'd0, sel_o}, 32'd7);
    chk("to_edit", {31'd0, editing_o}, 32'd0);
    chk("to_blink", {31'd0, blink_o}, 32'd0);
    chk("to_mode", {26'd0, mode_o}, 32'h3F);
    cyc(2);

    // Press after tick 2 postpones the timeout by 3 ticks
    for (int i = 0; i < 4; i++) press_mode((i == 0) ? 3'd7 : seq[i-1], seq[i]);
    tick(1'b1);
    tick(1'b0);
    pulse_btn(1'b0, 6'b001000);
    tick(1'b1);
    cyc(1);
    chk("to_delay_t3", {29'd0, sel_o}, 32'd3);
    tick(1'b0);
    cyc(1);
    chk("to_delay_t4", {29'd0, sel_o}, 32'd3);
    tick(1'b1);
    chk("to_delay_t5", {29'd0, sel_o}, 32'd3);
    cyc(1);
    chk("to_delay_run", {29'd0, sel_o}, 32'd7);
    cyc(2);

    // Held up in SET_HOUR: auto-repeat when enabled, single pulse otherwise
    press_mode(3'd7, 3'd2);
    btn_up = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      cyc(1);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      exp_up = (j == 3 || j == 11 || j == 15 || j == 19) ? 6'b000100 : 6'b000000;
`else
      exp_up = (j == 3) ? 6'b000100 : 6'b000000;
`endif
      chk($sformatf("hold_up_%0d", j), {26'd0, up_o}, {26'd0, exp_up});
      chk("hold_down", {26'd0, down_o}, 32'd0);
      if (j == 20) btn_up = 1'b0;
    end
    cyc(2);

    // Reset asserted while up is held mid-edit
    btn_up = 1'b1;
    cyc(10);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    btn_up = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cyc(1);
      chk("post_rst_up", {26'd0, up_o}, 32'd0);
      chk("post_rst_sel", {29'd0, sel_o}, 32'd7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed simulation still running expected finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the clock. It turns three raw push-buttons (mode, up, down) into a set-mode state machine that drives the per-field `mode_*`, `up` and `down` inputs of the six field counters: seconds, minutes, hours, days, months and years. It sits between the button pins and the counter chain, and exports field-select and blink information to the display driver.

## Interface
Parameters:
- TIMEOUT_S, default 10: idle seconds in a set state before the block returns to RUN; 0 disables the timeout.
- RPT_DELAY_CYC, default 25_000_000: held-button cycles before the first auto-repeat pulse.
- RPT_RATE_CYC, default 5_000_000: cycles between subsequent auto-repeat pulses.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_mode  in  1  debounced, asynchronous level, high = pressed
- btn_up  in  1  as btn_mode
- btn_down  in  1  as btn_mode
- tick_1hz  in  1  one-cycle strobe once per second
- mode_o  out  6  per-field mode; 1 = count ticks, 0 = set; bit index = field
- up_o  out  6  per-field one-cycle increment pulse
- down_o  out  6  per-field one-cycle decrement pulse
- sel_o  out  3  edited field index; 7 = none
- blink_o  out  1  display blank phase for the selected field
- editing_o  out  1  high in any set state

## Operation
- Field indices: SEC=0, MIN=1, HOUR=2, DAY=3, MONTH=4, YEAR=5.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC, SET_DAY, SET_MONTH, SET_YEAR.
- A mode press advances the state in the order RUN→HOUR→MIN→SEC→DAY→MONTH→YEAR→RUN.
- RUN outputs: mode_o=6'h3F, sel_o=7, editing_o=0, blink_o=0, and up_o/down_o are 0.
- Set-state outputs: mode_o=6'h00, which freezes the whole clock. sel_o is the field index and editing_o=1.
- Up/down in a set state: an up press pulses only up_o[sel_o], and a down press pulses only down_o[sel_o].
- Up/down in RUN: presses are ignored.
- Button conditioning: each button has a 2-flop synchronizer followed by a rising-edge detector. A press is the rising edge of the synchronized level.
- Simultaneous events:
  - up and down pressed in the same cycle: neither pulses.
  - mode together with up/down: mode wins, and up/down are dropped that cycle.
  - up held while down is pressed: down's edge pulses down_o only if up's synchronized level is 0; otherwise nothing.
- Timeout: an idle counter increments on tick_1hz while in a set state.
  - It clears on any accepted press and on every state change.
  - When it reaches TIMEOUT_S, the state goes to RUN at the next clk and the counter clears.
- Blink: blink_o is set to 0 on entry to any set state and toggles on each tick_1hz while editing.
- Reset mid-edit: the FSM goes to RUN and all outputs return to their reset values. No pulse is emitted.

## Timing
- Reset values: state RUN, mode_o=6'h3F, up_o=0, down_o=0, sel_o=3'd7, blink_o=0, editing_o=0. All synchronizer, idle and repeat counters are 0.
- Press latency: a button sampled high at clk edge k, after being low at edge k−1, gives a registered response in the cycle after edge k+2, i.e. 3 cycles:
  - up_o or down_o is high for exactly 1 cycle;
  - or the state/outputs update.
- Timeout latency: the state is RUN in the cycle after the tick_1hz that made the count equal TIMEOUT_S.
- Width rules:
  - idle counter width is $clog2(TIMEOUT_S+1), minimum 1;
  - repeat counter width is $clog2(max(RPT_DELAY_CYC, RPT_RATE_CYC)+1).

## Configuration
- Macro: CLOCK_SET_AUTO_REPEAT_EN.
- Defined, holding up or down in a set state:
  - the press pulse occurs first;
  - a further pulse follows RPT_DELAY_CYC cycles after it, then one every RPT_RATE_CYC cycles while held;
  - each repeat pulse clears the idle counter;
  - releasing the button or changing state clears the repeat counter.
- Undefined: exactly one pulse per press, no repeat counter logic.

## Structure
- Shared package clock_pkg:
  - field index localparams (FIELD_SEC … FIELD_YEAR, FIELD_NONE=3'd7);
  - NUM_FIELDS=6;
  - the state enum typedef set_state_t.
- Sub-module btn_cond, instantiated three times: synchronizer, edge detect and synchronized level output.
  - It also carries the repeat counter under CLOCK_SET_AUTO_REPEAT_EN; it is instantiated for up/down and tied off for mode.
- Top level holds the FSM, idle timer, blink and the output decode.

## Test plan
- Reset and RUN behaviour: release rst_n, pulse btn_up → mode_o=6'h3F, sel_o=7, and up_o stays 0 throughout.
- Mode cycling and latency: 7 mode presses → sel_o sequence 2,1,0,3,4,5,7, each update 3 cycles after the press, mode_o=0 in every set state.
- Field routing: in SET_MONTH press up twice and down once → up_o=6'b010000 twice and down_o=6'b010000 once, each 1 cycle wide, with all other bits 0.
- Simultaneous inputs:
  - up and down rising together → no pulse;
  - mode and up together in SET_HOUR → state becomes SET_MIN and up_o stays 0.
- Timeout and blink: TIMEOUT_S=3, enter SET_DAY, apply 3 tick_1hz strobes with no press → blink_o reads 1,0,1 after the strobes and the state is RUN after the 3rd. A press after tick 2 delays the return to RUN by 3 more ticks.
- Auto-repeat (macro defined) and reset mid-edit:
  - RPT_DELAY_CYC=8, RPT_RATE_CYC=4, hold up for 20 cycles → pulses at press+3, +8 and every 4 cycles after.
  - Assert rst_n low mid-hold → outputs return to reset values immediately.
